// File: rtl/adder_chk_pkg.sv
// Shared definitions for the adder response checker: adder variants,
// checker state encoding and the layout of the captured 5-bit vector record.
package adder_chk_pkg;

    localparam int ADDER_HALF = 0;
    localparam int ADDER_FULL = 1;

    // Vector record is {a, b, cin, sum, cout}, MSB first.
    localparam int VEC_W    = 5;
    localparam int VEC_A    = 4;
    localparam int VEC_B    = 3;
    localparam int VEC_CIN  = 2;
    localparam int VEC_SUM  = 1;
    localparam int VEC_COUT = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } chk_state_e;

    function automatic logic [VEC_W-1:0] pack_vec(input logic a, input logic b,
                                                  input logic cin, input logic sum,
                                                  input logic cout);
        return {a, b, cin, sum, cout};
    endfunction

endpackage

// File: rtl/adder_ref_model.sv
// Combinational reference for the 1-bit half/full adder selected by ADDER_TYPE.
// The half adder is the full adder with carry-in forced low.
module adder_ref_model
    import adder_chk_pkg::*;
#(
    parameter int ADDER_TYPE = ADDER_HALF
) (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic exp_sum,
    output logic exp_cout
);

    logic cin_eff;

    assign cin_eff  = (ADDER_TYPE == ADDER_FULL) ? cin : 1'b0;
    assign exp_sum  = a ^ b ^ cin_eff;
    assign exp_cout = (a & b) | (cin_eff & (a ^ b));

endmodule

// File: rtl/adder_resp_checker.sv
// Response checker for a 1-bit half/full adder: counts matches/mismatches over a
// run and latches the first failing vector. Optional: ADDER_CHK_STOP_ON_ERR_EN.
module adder_resp_checker
    import adder_chk_pkg::*;
#(
    parameter int ADDER_TYPE = ADDER_HALF,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    input  logic             sum,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [VEC_W-1:0] first_err_vec
);

    chk_state_e       state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] index_q, index_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
    logic [VEC_W-1:0] first_err_vec_q, first_err_vec_d;
    logic             first_err_vld_q, first_err_vld_d;

    logic exp_sum, exp_cout;
    logic accept, mismatch;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    adder_ref_model #(.ADDER_TYPE(ADDER_TYPE)) u_ref (
        .a       (a),
        .b       (b),
        .cin     (cin),
        .exp_sum (exp_sum),
        .exp_cout(exp_cout)
    );

    assign in_ready = (state_q == ST_CHECK);
    assign accept   = in_valid & in_ready;
    assign mismatch = (sum != exp_sum) | (cout != exp_cout);

    always_comb begin
        state_d         = state_q;
        target_d        = target_q;
        index_d         = index_q;
        pass_cnt_d      = pass_cnt_q;
        err_cnt_d       = err_cnt_q;
        first_err_idx_d = first_err_idx_q;
        first_err_vec_d = first_err_vec_q;
        first_err_vld_d = first_err_vld_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    target_d        = num_vectors;
                    index_d         = '0;
                    pass_cnt_d      = '0;
                    err_cnt_d       = '0;
                    first_err_idx_d = '0;
                    first_err_vec_d = '0;
                    first_err_vld_d = 1'b0;
                    state_d         = (num_vectors == '0) ? ST_DONE : ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    index_d = index_q + CNT_W'(1);
                    if (mismatch) begin
                        err_cnt_d = sat_inc(err_cnt_q);
                        if (!first_err_vld_q) begin
                            first_err_vld_d = 1'b1;
                            first_err_idx_d = index_q;
                            first_err_vec_d = pack_vec(a, b, cin, sum, cout);
                        end
                    end else begin
                        pass_cnt_d = sat_inc(pass_cnt_q);
                    end
                    if (index_q == target_q - CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
`ifdef ADDER_CHK_STOP_ON_ERR_EN
                    if (mismatch) begin
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            target_q        <= '0;
            index_q         <= '0;
            pass_cnt_q      <= '0;
            err_cnt_q       <= '0;
            first_err_idx_q <= '0;
            first_err_vec_q <= '0;
            first_err_vld_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            target_q        <= target_d;
            index_q         <= index_d;
            pass_cnt_q      <= pass_cnt_d;
            err_cnt_q       <= err_cnt_d;
            first_err_idx_q <= first_err_idx_d;
            first_err_vec_q <= first_err_vec_d;
            first_err_vld_q <= first_err_vld_d;
        end
    end

    assign busy          = (state_q == ST_CHECK);
    assign done          = (state_q == ST_DONE);
    assign pass          = done & (err_cnt_q == '0);
    assign pass_cnt      = pass_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_err_idx_q;
    assign first_err_vec = first_err_vec_q;

endmodule

// File: tb/tb_adder_resp_checker.sv
// Directed bench for adder_resp_checker: a half-adder and a full-adder instance
// share the stimulus; each scenario checks the instance it targets.
module tb_adder_resp_checker;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_vectors = '0;
    logic             in_valid = 1'b0;
    logic             a = 1'b0, b = 1'b0, cin = 1'b0, sum = 1'b0, cout = 1'b0;

    logic             h_ready, h_busy, h_done, h_pass;
    logic [CNT_W-1:0] h_pcnt, h_ecnt, h_fidx;
    logic [4:0]       h_fvec;
    logic             f_ready, f_busy, f_done, f_pass;
    logic [CNT_W-1:0] f_pcnt, f_ecnt, f_fidx;
    logic [4:0]       f_fvec;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adder_resp_checker #(.ADDER_TYPE(0), .CNT_W(CNT_W)) u_half (
        .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
        .in_valid(in_valid), .in_ready(h_ready),
        .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
        .busy(h_busy), .done(h_done), .pass(h_pass),
        .pass_cnt(h_pcnt), .err_cnt(h_ecnt),
        .first_err_idx(h_fidx), .first_err_vec(h_fvec)
    );

    adder_resp_checker #(.ADDER_TYPE(1), .CNT_W(CNT_W)) u_full (
        .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
        .in_valid(in_valid), .in_ready(f_ready),
        .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
        .busy(f_busy), .done(f_done), .pass(f_pass),
        .pass_cnt(f_pcnt), .err_cnt(f_ecnt),
        .first_err_idx(f_fidx), .first_err_vec(f_fvec)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks sample there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] n);
        start       = 1'b1;
        num_vectors = n;
        tick();
        start       = 1'b0;
    endtask

    task automatic send(input logic [4:0] v);
        {a, b, cin, sum, cout} = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // {a,b,cin,sum,cout}; entry 5 carries a wrong full-adder result.
    logic [4:0] full_vecs [8] = '{5'b00000, 5'b00110, 5'b01010, 5'b01101,
                                  5'b10010, 5'b10110, 5'b11001, 5'b11111};
    logic [4:0] half_vecs [4] = '{5'b00000, 5'b01110, 5'b11101, 5'b10110};

    initial begin
        // Reset values
        tick();
        chk("rst_busy", h_busy, 0);
        chk("rst_done", h_done, 0);
        chk("rst_pass", h_pass, 0);
        chk("rst_ready", h_ready, 0);
        chk("rst_pcnt", h_pcnt, 0);
        chk("rst_ecnt", h_ecnt, 0);
        rst = 1'b0;
        tick();

        // Half adder, four correct vectors (cin ignored)
        do_start(8'd4);
        chk("t1_busy", h_busy, 1);
        chk("t1_ready", h_ready, 1);
        for (int i = 0; i < 4; i++) send(half_vecs[i]);
        chk("t1_done", h_done, 1);
        chk("t1_pass", h_pass, 1);
        chk("t1_pcnt", h_pcnt, 4);
        chk("t1_ecnt", h_ecnt, 0);
        chk("t1_ready_off", h_ready, 0);

        // Full adder, all eight combos, vector 5 wrong
        do_start(8'd8);
        for (int i = 0; i < 8; i++) begin
            send(full_vecs[i]);
            if (i == 6) chk("t2_not_done", f_done, 0);
        end
        chk("t2_done", f_done, 1);
        chk("t2_ecnt", f_ecnt, 1);
        chk("t2_pcnt", f_pcnt, 7);
        chk("t2_fidx", f_fidx, 5);
        chk("t2_fvec", f_fvec, 5'b10110);
        chk("t2_pass", f_pass, 0);

        // Zero-length run, then a vector offered while in DONE
        do_start(8'd0);
        chk("t3_done", h_done, 1);
        chk("t3_pass", h_pass, 1);
        chk("t3_ready", h_ready, 0);
        chk("t3_busy", h_busy, 0);
        send(5'b11001);
        chk("t3_pcnt", h_pcnt, 0);
        chk("t3_ecnt", h_ecnt, 0);

        // Reset mid-run aborts at once
        do_start(8'd4);
        send(half_vecs[0]);
        send(half_vecs[1]);
        chk("t4_mid_pcnt", h_pcnt, 2);
        #2 rst = 1'b1;
        #1;
        chk("t4_rst_pcnt", h_pcnt, 0);
        chk("t4_rst_busy", h_busy, 0);
        chk("t4_rst_ready", h_ready, 0);
        tick();
        rst = 1'b0;
        do_start(8'd3);
        for (int i = 0; i < 3; i++) send(half_vecs[i]);
        chk("t4_done", h_done, 1);
        chk("t4_pcnt", h_pcnt, 3);
        chk("t4_pass", h_pass, 1);

        // Gaps between beats and a start pulse mid-run
        do_start(8'd4);
        for (int i = 0; i < 4; i++) begin
            send(half_vecs[i]);
            if (i == 0) begin
                start = 1'b1;
                num_vectors = 8'd1;
                tick();
                start = 1'b0;
                tick();
                tick();
            end else if (i < 3) begin
                repeat (3) tick();
            end
            if (i == 2) begin
                chk("t5_busy", h_busy, 1);
                chk("t5_pcnt3", h_pcnt, 3);
            end
        end
        chk("t5_done", h_done, 1);
        chk("t5_pcnt", h_pcnt, 4);
        chk("t5_ecnt", h_ecnt, 0);

        // Six-vector run with a bad vector at index 1
        do_start(8'd6);
        send(5'b00000);
        send(5'b01000);
`ifdef ADDER_CHK_STOP_ON_ERR_EN
        chk("t6_done", h_done, 1);
        chk("t6_ready", h_ready, 0);
        send(5'b11001);
        chk("t6_pcnt", h_pcnt, 1);
        chk("t6_ecnt", h_ecnt, 1);
        chk("t6_pass", h_pass, 0);
`else
        chk("t6_busy", h_busy, 1);
        for (int i = 0; i < 4; i++) send(half_vecs[i]);
        chk("t6_done", h_done, 1);
        chk("t6_pcnt", h_pcnt, 5);
        chk("t6_ecnt", h_ecnt, 1);
        chk("t6_pass", h_pass, 0);
`endif
        chk("t6_fidx", h_fidx, 1);
        chk("t6_fvec", h_fvec, 5'b01000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/adder_resp_checker.md
Name: adder_resp_checker

Overview:
- Synthesizable response checker for the 1-bit half/full adder selected by `ADDER_TYPE`.
- Sits on the output side of the adder: it accepts captured operand/result vectors (a, b, cin, sum, cout) and recomputes the expected result for the configured adder type.
- Counts passes and mismatches and latches the first failing vector.
- Used for on-chip self-test and as a bench scoreboard, replacing manual `$monitor` inspection.

Parameters:
- ADDER_TYPE, 0, adder variant under check: 0 = half adder (cin ignored), 1 = full adder.
- CNT_W, 8, width of vector count, pass/error counters and vector index.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  pulse; begins a check run of num_vectors vectors
- num_vectors  input  CNT_W  vectors expected in the run; sampled when start is accepted
- in_valid  input  1  vector present on a/b/cin/sum/cout
- in_ready  output  1  checker accepts a vector this cycle
- a  input  1  adder operand a
- b  input  1  adder operand b
- cin  input  1  adder carry-in
- sum  input  1  adder sum under test
- cout  input  1  adder carry-out under test
- busy  output  1  run in progress
- done  output  1  run complete; held until next start or reset
- pass  output  1  valid when done=1; 1 iff err_cnt==0
- pass_cnt  output  CNT_W  matching vectors this run
- err_cnt  output  CNT_W  mismatching vectors this run, saturating
- first_err_idx  output  CNT_W  index (0-based) of first mismatching vector
- first_err_vec  output  5  {a,b,cin,sum,cout} of first mismatching vector

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; internal index 0; first-error-valid flag 0.
- Expected-result function:
  - ADDER_TYPE=0: exp_sum=a^b, exp_cout=a&b; cin not compared.
  - ADDER_TYPE=1: exp_sum=a^b^cin, exp_cout=(a&b)|(cin&(a^b)).
  - Mismatch = (sum!=exp_sum)|(cout!=exp_cout).
- States: IDLE, CHECK, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start=1: latch num_vectors, clear counters, index and first-error state.
  - Next state CHECK, or DONE if num_vectors==0 (then pass=1).
- CHECK:
  - busy=1, in_ready=1.
  - Accept = in_valid & in_ready.
  - On accept, counters update at that edge: pass_cnt+1 on match, err_cnt+1 on mismatch, saturating at 2^CNT_W-1.
  - First mismatch only: latch first_err_idx=index and first_err_vec.
  - index increments on each accept.
  - When the accept with index==target-1 occurs, next state is DONE.
- DONE:
  - busy=0, done=1, in_ready=0.
  - pass reflects err_cnt==0; outputs held.
  - start=1 behaves as in IDLE: counters clear and a new run begins next cycle.
- Latency:
  - Counters and first-error registers are visible 1 cycle after the accepting edge.
  - done rises on the same edge that registers the final vector's result.
- Boundary conditions:
  - start during CHECK is ignored.
  - in_valid outside CHECK is ignored and not counted.
  - in_valid low in CHECK stalls with no timeout.
  - rst mid-run aborts immediately to reset values.
  - Saturated err_cnt still yields pass=0.
  - pass_cnt+err_cnt equals num_vectors at done unless saturation occurred.

Optional Feature:
- ADDER_CHK_STOP_ON_ERR_EN
- Defined: the first mismatch ends the run. Next state is DONE on that edge, with err_cnt=1, pass=0, and remaining vectors not accepted (in_ready=0).
- Undefined: all num_vectors vectors are checked regardless of mismatches.

Decomposition:
- Shared package adder_chk_pkg:
  - ADDER_HALF=0 and ADDER_FULL=1 constants.
  - State encoding typedef (IDLE/CHECK/DONE).
  - Width of the 5-bit vector record and its field order.
- One natural sub-module: adder_ref_model. It is combinational, parameterized by ADDER_TYPE, and outputs exp_sum/exp_cout, so the expected function is shared with other benches.

Test Plan:
- ADDER_TYPE=0, start with num_vectors=4, drive correct half-adder vectors (0,0,0→0,0), (0,1,1→1,0), (1,1,1→0,1), (1,0,1→1,0) → done=1, pass=1, pass_cnt=4, err_cnt=0.
- ADDER_TYPE=1, num_vectors=8, all 8 input combos with correct results except vector 5 (a=1,b=0,cin=1) given sum=1, cout=0 → err_cnt=1, pass_cnt=7, first_err_idx=5, first_err_vec=5'b10110, pass=0.
- num_vectors=0, start → DONE next cycle, pass=1, counters 0, in_ready never asserted.
- Reset asserted after 2 of 4 vectors accepted → outputs 0 immediately, state IDLE; new start with 3 vectors completes with pass_cnt=3.
- in_valid gaps of 3 cycles between vectors plus a start pulse mid-CHECK → start ignored, only valid beats counted, done after 4th accept.
- With ADDER_CHK_STOP_ON_ERR_EN, bad vector at index 1 of 6 → done after index 1 accept, err_cnt=1, pass_cnt=1, in_ready=0 thereafter.
